// File: rtl/param_sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// param_sync_fifo_pkg
//   Shared types and helpers for the parametrised single-clock FIFO.
//   - rst_state_e     : reset-busy sequencer states
//   - busy_cnt_width(): width of the post-reset busy counter
// -----------------------------------------------------------------------------
package param_sync_fifo_pkg;

  // StBusy covers both "in reset" and "counting busy edges after release".
  typedef enum logic [0:0] {
    StBusy  = 1'b0,
    StReady = 1'b1
  } rst_state_e;

  // Bits needed to hold values 0..last_val, never less than one bit.
  function automatic int unsigned busy_cnt_width(input int unsigned last_val);
    int unsigned w;
    if (last_val < 2) begin
      w = 1;
    end else begin
      w = $clog2(last_val + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_mem_1w1r.sv
// -----------------------------------------------------------------------------
// fifo_mem_1w1r
//   Flop-array storage with one synchronous write port and one asynchronous
//   read port. Contents are never reset.
//   Ports:
//     clk_i    rising-edge clock
//     we_i     write enable
//     waddr_i  write address
//     wdata_i  write data
//     raddr_i  read address
//     rdata_o  read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module fifo_mem_1w1r #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
//   Parametrised single-clock FIFO with standard or first-word-fall-through
//   read, occupancy count, almost-full/empty thresholds, sticky overflow and
//   underflow, and reset-busy outputs.
//   Ports:
//     clk, rst (async, active high)
//     wr_en, din          write request / data
//     rd_en, dout         read request / data
//     full, empty         status (forced to 1 while busy)
//     almost_full         count >= AFULL_THRESH (or busy)
//     almost_empty        count <= AEMPTY_THRESH (or busy)
//     count               entries held, 0..DEPTH
//     overflow, underflow sticky error flags
//     wr_rst_busy, rd_rst_busy  not ready after reset
// -----------------------------------------------------------------------------
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned FWFT            = 0,
  parameter int unsigned AFULL_THRESH    = 28,
  parameter int unsigned AEMPTY_THRESH   = 2,
  parameter int unsigned RST_BUSY_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  wr_rst_busy,
  output logic                  rd_rst_busy
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;
  localparam int unsigned BusyW = busy_cnt_width(RST_BUSY_CYCLES - 1);

  localparam logic [CntW-1:0]  CntFull   = CntW'(Depth);
  localparam logic [CntW-1:0]  CntAfull  = CntW'(AFULL_THRESH);
  localparam logic [CntW-1:0]  CntAempty = CntW'(AEMPTY_THRESH);
  localparam logic [BusyW-1:0] BusyLast  = BusyW'(RST_BUSY_CYCLES - 1);

  // Parameter legality
  if (AFULL_THRESH < 1 || AFULL_THRESH > Depth) begin : g_bad_afull
    $error("param_sync_fifo: AFULL_THRESH %0d outside 1..%0d", AFULL_THRESH, Depth);
  end
  if (AEMPTY_THRESH > Depth - 1) begin : g_bad_aempty
    $error("param_sync_fifo: AEMPTY_THRESH %0d outside 0..%0d", AEMPTY_THRESH, Depth - 1);
  end
  if (RST_BUSY_CYCLES < 1) begin : g_bad_busy
    $error("param_sync_fifo: RST_BUSY_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Reset-busy sequencer
  // ---------------------------------------------------------------------------
  rst_state_e       state_q, state_d;
  logic [BusyW-1:0] busy_cnt_q, busy_cnt_d;
  logic             busy;

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    unique case (state_q)
      StBusy: begin
        if (busy_cnt_q == BusyLast) begin
          state_d = StReady;
        end else begin
          busy_cnt_d = busy_cnt_q + BusyW'(1);
        end
      end
      StReady: state_d = StReady;
      default: state_d = StBusy;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBusy;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy = (state_q == StBusy);

  // ---------------------------------------------------------------------------
  // Pointers, occupancy and sticky errors
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_ok, wr_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Busy forces full and empty high, which blocks both ports without extra gating.
  always_comb begin
    full         = busy | (count_q == CntFull);
    empty        = busy | (count_q == '0);
    almost_full  = busy | (count_q >= CntAfull);
    almost_empty = busy | (count_q <= CntAempty);
  end

  // A write into a full FIFO still lands when the same cycle frees a slot.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (wr_en & full & ~rd_ok & ~busy) begin
      overflow_d = 1'b1;
    end
    if (rd_en & empty & ~busy) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  fifo_mem_1w1r #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
  if (FWFT == 0) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_ok) begin
        dout_d = mem_rdata;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign dout = dout_q;
  end else begin : g_fwft
    // Head entry is presented directly; masked while empty so reset reads as zero.
    assign dout = empty ? '0 : mem_rdata;
  end

  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign wr_rst_busy = busy;
  assign rd_rst_busy = busy;

endmodule
